fir_window_sequencer: RTL and testbench

FIR_WINDOW_SEQUENCER -- requirements
Module: fir_window_sequencer

---
 rtl/fir_window_sequencer_pkg.sv | 22 ++
 rtl/fir_window_sequencer_walker.sv | 70 +++++++
 rtl/fir_window_sequencer.sv | 179 +++++++++++++++++
 tb/tb_fir_window_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_window_sequencer_pkg.sv
// Shared constants and types for the FIR window sequencer.
// Holds the default width constants, the resolution-pair count and the
// sequencer FSM state encoding.
package fir_ds_pkg;

    localparam int X_ROM_LEN_LOG2               = 8;  // X window ROM address width
    localparam int Y_ROM_LEN_LOG2               = 8;  // Y window ROM address width
    localparam int MAX_X_DECIMATION_FACTOR_LOG2 = 4;  // X window value width
    localparam int MAX_Y_DECIMATION_FACTOR_LOG2 = 4;  // Y window value width
    localparam int NUM_RESLUTION_PAIR           = 8;  // number of resolution pairs
    localparam int RP_W                         = 3;  // resolution index width
    localparam int TW_W                         = 12; // target-width counter width

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CFG0 = 3'd1,
        ST_CFG1 = 3'd2,
        ST_CFG2 = 3'd3,
        ST_RUN  = 3'd4
    } state_t;

endpackage

// File: rtl/fir_window_sequencer_walker.sv
// window_addr_walker: steps through a circular list of window ROM addresses.
// Each address names a window whose length is win_val (0 treated as 1); after
// that many steps the address advances, wrapping from the end address back to
// the start address.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         load start/end addresses, clear the counters
//   start_addr   first address of the list (sampled on load)
//   end_addr     last address of the list (sampled on load)
//   step         one unit consumed this cycle
//   win_val      length of the window at addr
//   addr         current window ROM address
//   last         combinational: this step closes the current window
module window_addr_walker #(
    parameter int AW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    input  logic          step,
    input  logic [VW-1:0] win_val,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [AW-1:0] start_reg;
    logic [AW-1:0] span_reg;   // end - start, modulo AW bits
    logic [AW-1:0] addr_reg;
    logic [AW-1:0] move_reg;   // addresses advanced since the last wrap
    logic [VW-1:0] cnt_reg;
    logic [VW-1:0] cnt_max;

    // A zero-length window behaves like a one-step window.
    assign cnt_max = (win_val == '0) ? '0 : win_val - VW'(1);
    assign last    = step && (cnt_reg == cnt_max);
    assign addr    = addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_reg <= '0;
            span_reg  <= '0;
            addr_reg  <= '0;
            move_reg  <= '0;
            cnt_reg   <= '0;
        end else if (load) begin
            start_reg <= start_addr;
            span_reg  <= end_addr - start_addr;
            addr_reg  <= start_addr;
            move_reg  <= '0;
            cnt_reg   <= '0;
        end else if (step) begin
            if (cnt_reg == cnt_max) begin
                cnt_reg <= '0;
                if (move_reg == span_reg) begin
                    addr_reg <= start_reg;
                    move_reg <= '0;
                end else begin
                    addr_reg <= addr_reg + AW'(1);
                    move_reg <= move_reg + AW'(1);
                end
            end else begin
                cnt_reg <= cnt_reg + VW'(1);
            end
        end
    end

endmodule

// File: rtl/fir_window_sequencer.sv
// fir_window_sequencer: walks X and Y decimation-window ROM addresses for a
// selected resolution pair. A start pulse reads the pair's start/end entries
// from the shared start tables (registered read), then RUN advances the X
// window per accepted source pixel and the Y window per completed output line.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 latch res_idx/tar_width, (re)start configuration
//   res_idx, tar_width    resolution pair, X-output pixels per line
//   tab_addr              start-table address; xtab_data/ytab_data return 1 cycle later
//   xw/xwin_val           X window ROM address and its window length
//   yw/ywin_val           Y window ROM address and its window length
//   data_enable           source pixel accepted
//   en_output             X-output pixel consumed
//   x_win_last            combinational, pixel closes the current X window
//   y_win_last            registered 1-cycle pulse when a Y window closes
//   ready                 high in RUN
//   cfg_err               sticky, strobe seen outside RUN
module fir_window_sequencer #(
    parameter int X_ROM_LEN_LOG2               = fir_ds_pkg::X_ROM_LEN_LOG2,
    parameter int Y_ROM_LEN_LOG2               = fir_ds_pkg::Y_ROM_LEN_LOG2,
    parameter int MAX_X_DECIMATION_FACTOR_LOG2 = fir_ds_pkg::MAX_X_DECIMATION_FACTOR_LOG2,
    parameter int MAX_Y_DECIMATION_FACTOR_LOG2 = fir_ds_pkg::MAX_Y_DECIMATION_FACTOR_LOG2,
    parameter int NUM_RESLUTION_PAIR           = fir_ds_pkg::NUM_RESLUTION_PAIR,
    parameter int RP_W                         = fir_ds_pkg::RP_W,
    parameter int TW_W                         = fir_ds_pkg::TW_W
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [RP_W-1:0]                         res_idx,
    input  logic [TW_W-1:0]                         tar_width,
    output logic [RP_W:0]                           tab_addr,
    input  logic [X_ROM_LEN_LOG2-1:0]               xtab_data,
    input  logic [Y_ROM_LEN_LOG2-1:0]               ytab_data,
    output logic [X_ROM_LEN_LOG2-1:0]               xw,
    input  logic [MAX_X_DECIMATION_FACTOR_LOG2-1:0] xwin_val,
    output logic [Y_ROM_LEN_LOG2-1:0]               yw,
    input  logic [MAX_Y_DECIMATION_FACTOR_LOG2-1:0] ywin_val,
    input  logic                                    data_enable,
    input  logic                                    en_output,
    output logic                                    x_win_last,
    output logic                                    y_win_last,
    output logic                                    ready,
    output logic                                    cfg_err
);

    import fir_ds_pkg::*;

    localparam int XA = X_ROM_LEN_LOG2;
    localparam int YA = Y_ROM_LEN_LOG2;
    // Highest pair index with a populated table entry; out-of-range requests clamp here.
    localparam logic [RP_W:0] LAST_PAIR = (RP_W+1)'(NUM_RESLUTION_PAIR - 1);

    state_t          state_reg, state_next;
    logic [RP_W:0]   res_reg;
    logic [TW_W-1:0] tw_reg;
    logic [TW_W-1:0] ocnt_reg;
    logic [XA-1:0]   xs_reg;
    logic [YA-1:0]   ys_reg;
    logic [XA-1:0]   xe_next;
    logic [YA-1:0]   ye_next;
    logic            cfg_err_reg;
    logic            y_win_last_reg;
    logic            run;
    logic            load;
    logic            line_done;
    logic            y_last;

    assign run     = (state_reg == ST_RUN);
    assign load    = (state_reg == ST_CFG2);
    // Table holds the start of the next pair's list, so the end is one below it.
    assign xe_next = xtab_data - XA'(1);
    assign ye_next = ytab_data - YA'(1);

    // tar_width=0 turns every en_output into a line; otherwise the line closes
    // in the cycle after ocnt reaches tar_width, and en_output there is dropped.
    assign line_done = run && ((tw_reg == '0) ? en_output : (ocnt_reg == tw_reg));

    assign ready      = run;
    assign cfg_err    = cfg_err_reg;
    assign y_win_last = y_win_last_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tab_addr   = '0;
        case (state_reg)
            ST_IDLE: state_next = ST_IDLE;
            ST_CFG0: begin
                tab_addr   = res_reg;
                state_next = ST_CFG1;
            end
            ST_CFG1: begin
                tab_addr   = res_reg + (RP_W+1)'(1);
                state_next = ST_CFG2;
            end
            ST_CFG2: state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
        if (start) begin
            state_next = ST_CFG0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_reg        <= '0;
            tw_reg         <= '0;
            ocnt_reg       <= '0;
            xs_reg         <= '0;
            ys_reg         <= '0;
            cfg_err_reg    <= 1'b0;
            y_win_last_reg <= 1'b0;
        end else begin
            if (start) begin
                res_reg <= ({1'b0, res_idx} > LAST_PAIR) ? LAST_PAIR : {1'b0, res_idx};
                tw_reg  <= tar_width;
            end
            if (state_reg == ST_CFG1) begin
                xs_reg <= xtab_data;
                ys_reg <= ytab_data;
            end
            if (load) begin
                ocnt_reg <= '0;
            end else if (run) begin
                if (tw_reg == '0 || ocnt_reg == tw_reg) begin
                    ocnt_reg <= '0;
                end else if (en_output) begin
                    ocnt_reg <= ocnt_reg + TW_W'(1);
                end
            end
            if (start) begin
                cfg_err_reg <= 1'b0;
            end else if (!run && (data_enable || en_output)) begin
                cfg_err_reg <= 1'b1;
            end
            y_win_last_reg <= y_last;
        end
    end

    window_addr_walker #(
        .AW (XA),
        .VW (MAX_X_DECIMATION_FACTOR_LOG2)
    ) u_x_walker (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .start_addr (xs_reg),
        .end_addr   (xe_next),
        .step       (run && data_enable),
        .win_val    (xwin_val),
        .addr       (xw),
        .last       (x_win_last)
    );

    window_addr_walker #(
        .AW (YA),
        .VW (MAX_Y_DECIMATION_FACTOR_LOG2)
    ) u_y_walker (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .start_addr (ys_reg),
        .end_addr   (ye_next),
        .step       (line_done),
        .win_val    (ywin_val),
        .addr       (yw),
        .last       (y_last)
    );

endmodule

// File: tb/tb_fir_window_sequencer.sv
module tb_fir_window_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  res_idx;
    logic [11:0] tar_width;
    logic [3:0]  tab_addr;
    logic [7:0]  xtab_data;
    logic [7:0]  ytab_data;
    logic [7:0]  xw;
    logic [3:0]  xwin_val;
    logic [7:0]  yw;
    logic [3:0]  ywin_val;
    logic        data_enable;
    logic        en_output;
    logic        x_win_last;
    logic        y_win_last;
    logic        ready;
    logic        cfg_err;

    always #5 clk = ~clk;

    fir_window_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .res_idx     (res_idx),
        .tar_width   (tar_width),
        .tab_addr    (tab_addr),
        .xtab_data   (xtab_data),
        .ytab_data   (ytab_data),
        .xw          (xw),
        .xwin_val    (xwin_val),
        .yw          (yw),
        .ywin_val    (ywin_val),
        .data_enable (data_enable),
        .en_output   (en_output),
        .x_win_last  (x_win_last),
        .y_win_last  (y_win_last),
        .ready       (ready),
        .cfg_err     (cfg_err)
    );

    // Start tables with a one-cycle registered read.
    logic [7:0] xtab_mem [16];
    logic [7:0] ytab_mem [16];
    always @(posedge clk) begin
        xtab_data <= xtab_mem[tab_addr];
        ytab_data <= ytab_mem[tab_addr];
    end

    typedef struct packed {
        logic [7:0] addr;
        logic       last;
    } xexp_t;

    xexp_t      xq [$];
    logic [7:0] yq [$];
    int tests = 0;
    int fails = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every accepted pixel / Y-window pulse pops one expectation.
    xexp_t      xe;
    logic [7:0] ye;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ready && data_enable) begin
                if (xq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL x_unexpected: pixel at xw=0x%0h, no expectation", xw);
                end else begin
                    xe = xq.pop_front();
                    $display("[TB] x pixel xw=0x%0h last=%0b (exp 0x%0h/%0b)", xw, x_win_last, xe.addr, xe.last);
                    chk("x_addr", 32'(xw), 32'(xe.addr));
                    chk("x_last", 32'(x_win_last), 32'(xe.last));
                end
            end
            if (y_win_last) begin
                if (yq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL y_unexpected: y_win_last with yw=0x%0h, no expectation", yw);
                end else begin
                    ye = yq.pop_front();
                    $display("[TB] y window closed yw=0x%0h (exp 0x%0h)", yw, ye);
                    chk("y_addr", 32'(yw), 32'(ye));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_x(input logic [7:0] a, input logic l);
        xexp_t e;
        e.addr = a;
        e.last = l;
        xq.push_back(e);
    endtask

    task automatic drive_de(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            data_enable = 1'b1;
        end
        tick();
        data_enable = 1'b0;
    endtask

    // Issue start and check the CFG0/CFG1/CFG2 -> RUN handshake.
    task automatic do_start(input logic [2:0] r, input logic [11:0] tw,
                            input logic [7:0] exp_x, input logic [7:0] exp_y,
                            input logic strobe_in_cfg);
        tick();
        start     = 1'b1;
        res_idx   = r;
        tar_width = tw;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("cfg0_tab_addr", 32'(tab_addr), 32'(r));
        chk("cfg0_ready", 32'(ready), 32'd0);
        chk("cfg0_cfg_err", 32'(cfg_err), 32'd0);
        tick();
        en_output = strobe_in_cfg;
        @(negedge clk);
        chk("cfg1_tab_addr", 32'(tab_addr), 32'(r) + 32'd1);
        chk("cfg1_ready", 32'(ready), 32'd0);
        tick();
        en_output = 1'b0;
        @(negedge clk);
        chk("cfg2_ready", 32'(ready), 32'd0);
        tick();
        @(negedge clk);
        chk("run_ready", 32'(ready), 32'd1);
        chk("run_xw", 32'(xw), 32'(exp_x));
        chk("run_yw", 32'(yw), 32'(exp_y));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            xtab_mem[i] = 8'h00;
            ytab_mem[i] = 8'h00;
        end
        xtab_mem[2] = 8'h10; xtab_mem[3] = 8'h14;
        ytab_mem[2] = 8'h20; ytab_mem[3] = 8'h23;
        xtab_mem[4] = 8'h30; xtab_mem[5] = 8'h31;
        ytab_mem[4] = 8'h40; ytab_mem[5] = 8'h41;

        rst_n       = 1'b0;
        start       = 1'b0;
        res_idx     = 3'd0;
        tar_width   = 12'd0;
        xwin_val    = 4'd1;
        ywin_val    = 4'd1;
        data_enable = 1'b0;
        en_output   = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_xw", 32'(xw), 32'd0);
        chk("rst_yw", 32'(yw), 32'd0);
        chk("rst_tab_addr", 32'(tab_addr), 32'd0);
        chk("rst_y_win_last", 32'(y_win_last), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_x_win_last", 32'(x_win_last), 32'd0);
        tick();
        rst_n = 1'b1;

        // data_enable in IDLE: error flag, no address movement
        tick();
        data_enable = 1'b1;
        @(negedge clk);
        chk("idle_x_win_last", 32'(x_win_last), 32'd0);
        tick();
        data_enable = 1'b0;
        @(negedge clk);
        chk("idle_cfg_err", 32'(cfg_err), 32'd1);
        chk("idle_xw", 32'(xw), 32'd0);

        // Configure pair 2: X 0x10..0x13, Y 0x20..0x22
        do_start(3'd2, 12'd4, 8'h10, 8'h20, 1'b0);

        // xwin_val=3, 12 pixels: each address for 3 pixels, wrapping at 0x13
        xwin_val = 4'd3;
        for (int i = 0; i < 12; i++) begin
            push_x(8'h10 + 8'((i / 3) % 4), (i % 3) == 2);
        end
        drive_de(12);
        @(negedge clk);
        chk("x_wrap_xw", 32'(xw), 32'h10);

        // xwin_val=0 behaves as 1
        xwin_val = 4'd0;
        push_x(8'h10, 1'b1); push_x(8'h11, 1'b1); push_x(8'h12, 1'b1);
        push_x(8'h13, 1'b1); push_x(8'h10, 1'b1);
        drive_de(5);
        @(negedge clk);
        chk("x_zero_xw", 32'(xw), 32'h11);

        // Leave X mid-window so the restart must clear the counter
        xwin_val = 4'd3;
        push_x(8'h11, 1'b0);
        drive_de(1);

        // Y walk: tar_width=4, ywin_val=2, two lines -> one Y window
        ywin_val = 4'd2;
        yq.push_back(8'h21);
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                en_output = 1'b1;
            end
            tick();
            en_output = 1'b0;
        end
        repeat (3) tick();
        @(negedge clk);
        chk("y_adv_yw", 32'(yw), 32'h21);
        chk("y_pulse_done", 32'(y_win_last), 32'd0);

        // Restart mid-RUN on pair 4 (single-entry lists), strobe during CFG1
        xwin_val = 4'd2;
        ywin_val = 4'd1;
        do_start(3'd4, 12'd0, 8'h30, 8'h40, 1'b1);
        chk("cfg_strobe_err", 32'(cfg_err), 32'd1);
        push_x(8'h30, 1'b0); push_x(8'h30, 1'b1);
        push_x(8'h30, 1'b0); push_x(8'h30, 1'b1);
        drive_de(4);
        @(negedge clk);
        chk("x_single_xw", 32'(xw), 32'h30);

        // tar_width=0 with simultaneous data_enable/en_output
        push_x(8'h30, 1'b0); push_x(8'h30, 1'b1);
        yq.push_back(8'h40); yq.push_back(8'h40);
        for (int i = 0; i < 2; i++) begin
            tick();
            data_enable = 1'b1;
            en_output   = 1'b1;
        end
        tick();
        data_enable = 1'b0;
        en_output   = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("y_single_yw", 32'(yw), 32'h40);

        // Asynchronous reset mid-RUN
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'd0);
        chk("arst_xw", 32'(xw), 32'd0);
        chk("arst_yw", 32'(yw), 32'd0);
        chk("arst_tab_addr", 32'(tab_addr), 32'd0);
        chk("arst_cfg_err", 32'(cfg_err), 32'd0);
        chk("arst_y_win_last", 32'(y_win_last), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("post_rst_ready", 32'(ready), 32'd0);

        chk("x_queue_empty", 32'(xq.size()), 32'd0);
        chk("y_queue_empty", 32'(yq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
